// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - 800x600 scan-out: 4x upscaled framebuffer read, palette lookup, frame-synchronous buffer swap
// Three register stages keep colour, syncs and data enable aligned at the pins.
module vga_fb_scanout #(
  parameter int FB_W   = 200,
  parameter int FB_H   = 150,
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 4
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              de,
  input  logic              frame,
  output logic [ADDR_W:0]   fb_addr,
  output logic              fb_rd_en,
  input  logic [PIX_W-1:0]  fb_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              fb_sel,
  input  logic              pal_we,
  input  logic [PIX_W-1:0]  pal_idx,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de
);

  localparam int X_W   = $clog2(FB_W);
  localparam int Y_W   = $clog2(FB_H);
  localparam int PAL_N = 1 << PIX_W;

  logic [ADDR_W-1:0] x_cell;
  logic [ADDR_W-1:0] y_cell;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] pix_addr;
  logic              hs1, vs1, de1;
  logic              hs2, vs2, de2;
  logic              pending;
  logic [11:0]       pal [PAL_N];
  logic              unused_bits;

  // Each framebuffer pixel covers a 4x4 block of screen pixels.
  assign x_cell      = ADDR_W'(sx[2 +: X_W]);
  assign y_cell      = ADDR_W'(sy[2 +: Y_W]);
  assign unused_bits = ^{sx[1:0], sy[1:0]};

  if (FB_W == 200) begin : g_row_shift_add
    assign row_base = (y_cell << 7) + (y_cell << 6) + (y_cell << 3);
  end else begin : g_row_mul
    assign row_base = y_cell * ADDR_W'(FB_W);
  end

  assign pix_addr = row_base + x_cell;

  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      fb_addr  <= '0;
      fb_rd_en <= 1'b0;
      hs1      <= 1'b1;
      vs1      <= 1'b1;
      de1      <= 1'b0;
      hs2      <= 1'b1;
      vs2      <= 1'b1;
      de2      <= 1'b0;
    end else begin
      fb_addr  <= {fb_sel, pix_addr};
      fb_rd_en <= de;
      hs1      <= hsync;
      vs1      <= vsync;
      de1      <= de;
      hs2      <= hs1;
      vs2      <= vs1;
      de2      <= de1;
    end
  end

  // fb_data is the BRAM output register, so the palette reads it directly.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_de <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= de2 ? pal[fb_data] : 12'h000;
      vga_hs <= hs2;
      vga_vs <= vs2;
      vga_de <= de2;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      for (int i = 0; i < PAL_N; i++) begin
        pal[PIX_W'(i)] <= {3{i[3:0]}};
      end
    end else if (pal_we) begin
      pal[pal_idx] <= pal_rgb;
    end
  end

  // A request landing on the consuming edge is absorbed by that swap.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      fb_sel   <= 1'b0;
      swap_ack <= 1'b0;
      pending  <= 1'b0;
    end else if (frame && (pending || swap_req)) begin
      fb_sel   <= ~fb_sel;
      swap_ack <= 1'b1;
      pending  <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
